// File: rtl/mem_line_engine_pkg.sv
// rtl/mem_line_engine_pkg.sv - shared state encoding and sizing helpers for the line engine
package mem_line_engine_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_REQ,
    S_RD_DATA,
    S_WR_REQ,
    S_WR_DATA,
    S_DONE
  } state_e;

  localparam int DEFAULT_BEATS = 4;

  // Width of the beat index; a single-beat line still needs one bit of index.
  function automatic int beat_idx_bits(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/mem_line_buffer.sv
// rtl/mem_line_buffer.sv - BEATS x DATA_BITS line register file with beat write and line load
module mem_line_buffer
  import mem_line_engine_pkg::*;
#(
  parameter int BEATS     = DEFAULT_BEATS,
  parameter int DATA_BITS = 128,
  parameter int IDX_W     = beat_idx_bits(BEATS)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic [IDX_W-1:0]           wr_idx,
  input  logic [DATA_BITS-1:0]       wr_data,
  input  logic                       load_en,
  input  logic [BEATS*DATA_BITS-1:0] load_line,
  output logic [BEATS*DATA_BITS-1:0] line_out
);

  logic [BEATS*DATA_BITS-1:0] line_d, line_q;

  // A full-line load (writeback capture) takes priority over a single refill beat.
  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (wr_en) begin
      line_d[int'(wr_idx)*DATA_BITS +: DATA_BITS] = wr_data;
    end
  end

  // Line storage register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_out = line_q;

endmodule

// File: rtl/mem_line_engine.sv
// rtl/mem_line_engine.sv - cache-line refill/writeback engine driving the memory beat protocol
module mem_line_engine
  import mem_line_engine_pkg::*;
#(
  parameter int ADDR_BITS = 28,
  parameter int DATA_BITS = 128,
  parameter int TAG_BITS  = 5,
  parameter int BEATS     = DEFAULT_BEATS
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      line_req_valid,
  output logic                                      line_req_ready,
  input  logic                                      line_req_rw,
  input  logic [ADDR_BITS-beat_idx_bits(BEATS)-1:0] line_req_addr,
  input  logic [BEATS*DATA_BITS-1:0]                line_req_data,
  output logic                                      line_resp_valid,
  output logic                                      line_resp_rw,
  output logic [BEATS*DATA_BITS-1:0]                line_resp_data,
  output logic                                      line_err,
  output logic                                      mem_req_valid,
  input  logic                                      mem_req_ready,
  output logic                                      mem_req_rw,
  output logic [ADDR_BITS-1:0]                      mem_req_addr,
  output logic [TAG_BITS-1:0]                       mem_req_tag,
  output logic                                      mem_req_data_valid,
  input  logic                                      mem_req_data_ready,
  output logic [DATA_BITS-1:0]                      mem_req_data_bits,
  output logic [DATA_BITS/8-1:0]                    mem_req_data_mask,
  input  logic                                      mem_resp_valid,
  input  logic [DATA_BITS-1:0]                      mem_resp_data,
  input  logic [TAG_BITS-1:0]                       mem_resp_tag
);

  localparam int IDX_W = beat_idx_bits(BEATS);
  localparam int LINE_W = ADDR_BITS - IDX_W;
  localparam int LINE_BITS = BEATS * DATA_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

  state_e                state_d, state_q;
  logic [IDX_W-1:0]      beat_idx_d, beat_idx_q;
  logic [TAG_BITS-1:0]   tag_d, tag_q;
  logic [TAG_BITS-1:0]   tag_cnt_d, tag_cnt_q;
  logic [LINE_W-1:0]     addr_d, addr_q;
  logic                  rw_d, rw_q;
  logic                  err_d, err_q;
  logic                  req_valid_d, req_valid_q;
  logic                  data_valid_d, data_valid_q;
  logic                  resp_valid_d, resp_valid_q;
  logic [LINE_BITS-1:0]  resp_data_d, resp_data_q;
  logic [LINE_BITS-1:0]  buf_line;
  logic [LINE_BITS-1:0]  merged_line;
  logic                  beat_wr;
  logic                  line_load;

  assign beat_wr   = (state_q == S_RD_DATA) && mem_resp_valid;
  assign line_load = (state_q == S_IDLE) && line_req_valid && line_req_rw;

  mem_line_buffer #(
    .BEATS     (BEATS),
    .DATA_BITS (DATA_BITS),
    .IDX_W     (IDX_W)
  ) u_buf (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (beat_wr),
    .wr_idx    (beat_idx_q),
    .wr_data   (mem_resp_data),
    .load_en   (line_load),
    .load_line (line_req_data),
    .line_out  (buf_line)
  );

  // Final beat bypasses the buffer so the completed line is visible alongside the pulse.
  always_comb begin
    merged_line = buf_line;
    merged_line[int'(beat_idx_q)*DATA_BITS +: DATA_BITS] = mem_resp_data;
  end

  // Next-state and registered-output computation for the line FSM.
  always_comb begin
    state_d      = state_q;
    beat_idx_d   = beat_idx_q;
    tag_d        = tag_q;
    tag_cnt_d    = tag_cnt_q;
    addr_d       = addr_q;
    rw_d         = rw_q;
    err_d        = err_q;
    req_valid_d  = req_valid_q;
    data_valid_d = data_valid_q;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;

    // Stray read beats outside a refill are dropped but flagged.
    if (mem_resp_valid && (state_q != S_RD_DATA)) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (line_req_valid) begin
          addr_d      = line_req_addr;
          rw_d        = line_req_rw;
          tag_d       = tag_cnt_q;
          tag_cnt_d   = tag_cnt_q + TAG_BITS'(1);
          beat_idx_d  = '0;
          req_valid_d = 1'b1;
          state_d     = line_req_rw ? S_WR_REQ : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (mem_resp_valid) begin
          if (mem_resp_tag != tag_q) begin
            err_d = 1'b1;
          end
          if (beat_idx_q == LAST_IDX) begin
            resp_data_d  = merged_line;
            resp_valid_d = 1'b1;
            beat_idx_d   = '0;
            state_d      = S_DONE;
          end else begin
            beat_idx_d = beat_idx_q + IDX_W'(1);
          end
        end
      end
      S_WR_REQ: begin
        if (mem_req_ready) begin
          req_valid_d  = 1'b0;
          data_valid_d = 1'b1;
          state_d      = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (mem_req_data_ready) begin
          data_valid_d = 1'b0;
          if (beat_idx_q == LAST_IDX) begin
            resp_valid_d = 1'b1;
            beat_idx_d   = '0;
            state_d      = S_DONE;
          end else begin
            beat_idx_d  = beat_idx_q + IDX_W'(1);
            req_valid_d = 1'b1;
            state_d     = S_WR_REQ;
          end
        end
      end
      S_DONE: begin
        resp_valid_d = 1'b0;
        beat_idx_d   = '0;
        state_d      = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM state and registered outputs; reset abandons any op in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      beat_idx_q   <= '0;
      tag_q        <= '0;
      tag_cnt_q    <= '0;
      addr_q       <= '0;
      rw_q         <= 1'b0;
      err_q        <= 1'b0;
      req_valid_q  <= 1'b0;
      data_valid_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      beat_idx_q   <= beat_idx_d;
      tag_q        <= tag_d;
      tag_cnt_q    <= tag_cnt_d;
      addr_q       <= addr_d;
      rw_q         <= rw_d;
      err_q        <= err_d;
      req_valid_q  <= req_valid_d;
      data_valid_q <= data_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign line_req_ready     = (state_q == S_IDLE);
  assign line_resp_valid    = resp_valid_q;
  assign line_resp_rw       = rw_q;
  assign line_resp_data     = resp_data_q;
  assign line_err           = err_q;
  assign mem_req_valid      = req_valid_q;
  assign mem_req_rw         = rw_q;
  assign mem_req_addr       = {addr_q, beat_idx_q};
  assign mem_req_tag        = tag_q;
  assign mem_req_data_valid = data_valid_q;
  assign mem_req_data_bits  = buf_line[int'(beat_idx_q)*DATA_BITS +: DATA_BITS];
  assign mem_req_data_mask  = '1;

endmodule
